// File: rtl/resize_copy_sequencer.sv
// Sequencer for the ROM->framebuffer copier: debounces the mode switches, commits a scaling mode,
// runs one supervised copy pass (timeout + retries) and blanks/unblanks the display on frame ticks.
module resize_copy_sequencer #(
    parameter int SEL_W          = 4,
    parameter int STABLE_CYCLES  = 500000,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int MAX_RETRY      = 2
) (
    input  logic             clk_50MHz,
    input  logic             vga_reset,
    input  logic [SEL_W-1:0] sw,
    input  logic             frame_tick,
    input  logic             copier_done,
    output logic             copier_start,
    output logic [SEL_W-1:0] copier_seletor,
    output logic             display_enable,
    output logic             busy,
    output logic             error
);

    localparam int STB_W = $clog2(STABLE_CYCLES + 1);
    localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [STB_W-1:0] STB_MAX    = STB_W'(STABLE_CYCLES);
    localparam logic [STB_W-1:0] STB_COMMIT = STB_W'(STABLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RTY_W-1:0] RTY_MAX    = RTY_W'(MAX_RETRY);

    localparam logic [2:0] ST_SETTLE     = 3'd0;
    localparam logic [2:0] ST_WAIT_BLANK = 3'd1;
    localparam logic [2:0] ST_START      = 3'd2;
    localparam logic [2:0] ST_COPY       = 3'd3;
    localparam logic [2:0] ST_WAIT_SHOW  = 3'd4;
    localparam logic [2:0] ST_SHOW       = 3'd5;
    localparam logic [2:0] ST_FAULT      = 3'd6;

    logic [SEL_W-1:0] sw_meta_q, sw_sync_q;
    logic [SEL_W-1:0] cand_q, cand_d;
    logic [STB_W-1:0] stable_cnt_q, stable_cnt_d;
    logic [2:0]       state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [RTY_W-1:0] retry_q, retry_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             pending_q, pending_d;
    logic             disp_q, disp_d;
    logic             err_q, err_d;
    logic             first_pass_q, first_pass_d;
    logic             done_low_seen_q, done_low_seen_d;
    logic             start_q, busy_q;
    logic             commit_req;

    always_comb begin
        cand_d       = cand_q;
        stable_cnt_d = stable_cnt_q;
        if (sw_sync_q != cand_q) begin
            cand_d       = sw_sync_q;
            stable_cnt_d = '0;
        end else if (stable_cnt_q != STB_MAX) begin
            stable_cnt_d = stable_cnt_q + 1'b1;
        end
    end

    // Fires once per stable run: the counter passes STABLE_CYCLES-1 only once before saturating.
    assign commit_req = (stable_cnt_q == STB_COMMIT) && ((cand_q != sel_q) || first_pass_q);

    always_comb begin
        state_d         = state_q;
        sel_d           = sel_q;
        retry_d         = retry_q;
        timer_d         = timer_q;
        pending_d       = pending_q;
        disp_d          = disp_q;
        err_d           = err_q;
        first_pass_d    = first_pass_q;
        done_low_seen_d = done_low_seen_q;
        case (state_q)
            ST_SETTLE, ST_SHOW: begin
                if (commit_req) begin
                    sel_d   = cand_q;
                    retry_d = '0;
                    err_d   = 1'b0;
                    state_d = ST_WAIT_BLANK;
                end
            end
            ST_WAIT_BLANK: begin
                if (commit_req) sel_d = cand_q;
                if (frame_tick) begin
                    disp_d  = 1'b0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                timer_d         = '0;
                done_low_seen_d = 1'b0;
                first_pass_d    = 1'b0;
                if (commit_req) pending_d = 1'b1;
                state_d = ST_COPY;
            end
            ST_COPY: begin
                if (commit_req) pending_d = 1'b1;
                if (!copier_done) done_low_seen_d = 1'b1;
                // A done level left high by the previous pass only counts once it has been seen low.
                if (done_low_seen_q && copier_done) begin
                    state_d = ST_WAIT_SHOW;
                end else if (timer_q == TMR_LAST) begin
                    if (retry_q < RTY_MAX) begin
                        retry_d = retry_q + 1'b1;
                        state_d = ST_START;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_FAULT;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_WAIT_SHOW: begin
                if (pending_q || commit_req) begin
                    pending_d = 1'b0;
                    sel_d     = cand_q;
                    retry_d   = '0;
                    state_d   = ST_START;
                end else if (frame_tick) begin
                    disp_d  = 1'b1;
                    state_d = ST_SHOW;
                end
            end
            ST_FAULT: begin
                disp_d = 1'b0;
                if (commit_req || pending_q) begin
                    pending_d = 1'b0;
                    sel_d     = cand_q;
                    retry_d   = '0;
                    err_d     = 1'b0;
                    state_d   = ST_WAIT_BLANK;
                end
            end
            default: state_d = ST_SETTLE;
        endcase
    end

    always_ff @(posedge clk_50MHz or negedge vga_reset) begin
        if (!vga_reset) begin
            sw_meta_q       <= '0;
            sw_sync_q       <= '0;
            cand_q          <= '0;
            stable_cnt_q    <= '0;
            state_q         <= ST_SETTLE;
            sel_q           <= '0;
            retry_q         <= '0;
            timer_q         <= '0;
            pending_q       <= 1'b0;
            disp_q          <= 1'b0;
            err_q           <= 1'b0;
            first_pass_q    <= 1'b1;
            done_low_seen_q <= 1'b0;
            start_q         <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            sw_meta_q       <= sw;
            sw_sync_q       <= sw_meta_q;
            cand_q          <= cand_d;
            stable_cnt_q    <= stable_cnt_d;
            state_q         <= state_d;
            sel_q           <= sel_d;
            retry_q         <= retry_d;
            timer_q         <= timer_d;
            pending_q       <= pending_d;
            disp_q          <= disp_d;
            err_q           <= err_d;
            first_pass_q    <= first_pass_d;
            done_low_seen_q <= done_low_seen_d;
            start_q         <= (state_q == ST_START);
            busy_q          <= (state_d != ST_SHOW) && (state_d != ST_FAULT);
        end
    end

    assign copier_start   = start_q;
    assign copier_seletor = sel_q;
    assign display_enable = disp_q;
    assign busy           = busy_q;
    assign error          = err_q;

endmodule

// File: tb/tb_resize_copy_sequencer.sv
// Bench for resize_copy_sequencer: randomized switch/copier/frame-tick stimulus checked against
// an event-level model of the pass rules (debounce, blanking on ticks, retries, fault, reset).
module tb_resize_copy_sequencer;

    localparam int SEL_W   = 4;
    localparam int STABLE  = 8;
    localparam int TIMEOUT = 64;
    localparam int RETRY   = 2;

    localparam int CP_NORMAL = 0;
    localparam int CP_NEVER  = 1;
    localparam int CP_STUCK  = 2;
    localparam int CP_COINC  = 3;

    logic             clk_50MHz = 1'b0;
    logic             vga_reset;
    logic [SEL_W-1:0] sw;
    logic             frame_tick;
    logic             copier_done;
    logic             copier_start;
    logic [SEL_W-1:0] copier_seletor;
    logic             display_enable;
    logic             busy;
    logic             error;

    always #5 clk_50MHz = ~clk_50MHz;

    resize_copy_sequencer #(
        .SEL_W(SEL_W), .STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(TIMEOUT), .MAX_RETRY(RETRY)
    ) dut (
        .clk_50MHz(clk_50MHz), .vga_reset(vga_reset), .sw(sw), .frame_tick(frame_tick),
        .copier_done(copier_done), .copier_start(copier_start), .copier_seletor(copier_seletor),
        .display_enable(display_enable), .busy(busy), .error(error)
    );

    int n_checks = 0;
    int n_err    = 0;

    int cyc = 0;
    int tick_period = 100, tick_cnt = 0, last_tick = -1000;
    int cp_mode = CP_NORMAL, cp_lat = 20, cp_hi = 0, cp_lo = 0;
    int n_starts = 0, last_start = 0, start_sel = 0;
    int ticks_after_done = 0, done_rise_cyc = 0, expect_start_at = -1, disp_hi_cnt = 0;
    bit in_pass = 0, pass_done = 0, midpass_change = 0, disp_prev = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int pick_new(input int cur, input int avoid);
        int v;
        do v = int'($urandom_range(1, 15)); while (v == cur || v == avoid);
        return v;
    endfunction

    // One clock: observe outputs on the falling edge, apply the pass rules, then drive inputs.
    task automatic step();
        @(negedge clk_50MHz);
        cyc++;
        if (expect_start_at == cyc) begin
            check_eq("start_after_blank", int'(copier_start), 1);
            expect_start_at = -1;
        end
        if (copier_start) begin
            n_starts++;
            last_start       = cyc;
            start_sel        = int'(copier_seletor);
            in_pass          = 1;
            pass_done        = 0;
            ticks_after_done = 0;
        end else if (in_pass && int'(copier_seletor) != start_sel) begin
            midpass_change = 1;
        end
        if (display_enable) disp_hi_cnt++;
        if (display_enable && !disp_prev) begin
            check_eq("show_after_done", int'(pass_done), 1);
            check_eq("show_on_next_tick", int'(ticks_after_done == 1 && last_tick == cyc - 1), 1);
        end
        if (!display_enable && disp_prev) begin
            check_eq("blank_on_tick", int'(last_tick == cyc - 1), 1);
            expect_start_at = cyc + 1;
        end
        disp_prev = display_enable;

        tick_cnt++;
        frame_tick = (tick_cnt >= tick_period);
        if (frame_tick) begin
            tick_cnt  = 0;
            last_tick = cyc;
            if (pass_done) ticks_after_done++;
        end

        if (copier_start) begin
            cp_hi = (cp_mode == CP_STUCK) ? 30 : 0;
            cp_lo = (cp_mode == CP_NEVER) ? 0 : cp_lat;
            if (cp_hi == 0) copier_done = 1'b0;
        end else if (cp_hi > 0) begin
            cp_hi--;
            if (cp_hi == 0) copier_done = 1'b0;
        end else if (cp_lo > 0) begin
            if (cp_lo > 1) cp_lo--;
            else if (cp_mode != CP_COINC || frame_tick) begin
                cp_lo            = 0;
                copier_done      = 1'b1;
                pass_done        = 1;
                in_pass          = 0;
                ticks_after_done = 0;
                done_rise_cyc    = cyc;
            end
        end
    endtask

    task automatic wait_starts(input int target, input int budget, input string tag);
        int b = budget;
        while (n_starts < target && b > 0) begin
            step();
            b--;
        end
        check_eq(tag, n_starts, target);
    endtask

    task automatic wait_disp(input int val, input int budget, input string tag);
        int b = budget;
        while (int'(display_enable) != val && b > 0) begin
            step();
            b--;
        end
        check_eq(tag, int'(display_enable), val);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cur, a, b, s0, t1, rel;
        vga_reset   = 1'b1;
        sw          = '0;
        frame_tick  = 1'b0;
        copier_done = 1'b0;
        #1 vga_reset = 1'b0;
        repeat (3) step();
        check_eq("rst_start", int'(copier_start), 0);
        check_eq("rst_sel", int'(copier_seletor), 0);
        check_eq("rst_display", int'(display_enable), 0);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_error", int'(error), 0);
        vga_reset = 1'b1;

        // Power-up with switches at 0000: one pass, then shown.
        wait_disp(1, 600, "s1_show");
        check_eq("s1_starts", n_starts, 1);
        check_eq("s1_sel_at_start", start_sel, 0);
        check_eq("s1_busy", int'(busy), 0);
        check_eq("s1_error", int'(error), 0);
        repeat (50) step();
        check_eq("s1_single_pass", n_starts, 1);
        cur = 0;

        // Glitchy switch change while shown; second round lands done exactly on a frame tick.
        for (int i = 0; i < 2; i++) begin
            cp_mode     = (i == 1) ? CP_COINC : CP_NORMAL;
            tick_period = (i == 1) ? 40 : int'($urandom_range(40, 120));
            cp_lat      = (i == 1) ? 5 : int'($urandom_range(5, 40));
            a  = pick_new(cur, cur);
            s0 = n_starts;
            for (int g = 0; g < 3; g++) begin
                sw = SEL_W'(a);
                repeat ($urandom_range(1, 5)) step();
                sw = SEL_W'(pick_new(a, a));
                repeat ($urandom_range(1, 5)) step();
            end
            check_eq("s3_no_early_pass", n_starts, s0);
            sw = SEL_W'(a);
            wait_starts(s0 + 1, 400, "s3_pass_started");
            check_eq("s3_sel", start_sel, a);
            wait_disp(1, 600, "s3_show");
            repeat (30) step();
            check_eq("s3_one_pass", n_starts, s0 + 1);
            check_eq("s3_seletor", int'(copier_seletor), a);
            cur = a;
        end

        // Switch change during COPY: held until done, then immediate restart, display stays low.
        tick_period = 100;
        cp_mode     = CP_NORMAL;
        cp_lat      = 40;
        a  = pick_new(cur, cur);
        b  = pick_new(a, cur);
        s0 = n_starts;
        sw = SEL_W'(a);
        wait_starts(s0 + 1, 400, "s4_first_start");
        check_eq("s4_first_sel", start_sel, a);
        check_eq("s4_busy", int'(busy), 1);
        midpass_change = 0;
        disp_hi_cnt    = 0;
        repeat (8) step();
        sw = SEL_W'(b);
        wait_starts(s0 + 2, 200, "s4_restart");
        check_eq("s4_restart_immediate", int'(cyc - done_rise_cyc <= 4), 1);
        check_eq("s4_restart_sel", start_sel, b);
        check_eq("s4_no_midpass_change", int'(midpass_change), 0);
        check_eq("s4_display_kept_low", disp_hi_cnt, 0);
        wait_disp(1, 600, "s4_show");
        check_eq("s4_seletor", int'(copier_seletor), b);
        cur = b;

        // Copier never finishes: initial attempt + RETRY retries, then FAULT.
        cp_mode = CP_NEVER;
        a  = pick_new(cur, cur);
        s0 = n_starts;
        sw = SEL_W'(a);
        wait_starts(s0 + 1, 400, "s5_start1");
        t1 = cyc;
        wait_starts(s0 + 2, 100, "s5_start2");
        check_eq("s5_retry_gap1", int'(cyc - t1 >= TIMEOUT && cyc - t1 <= TIMEOUT + 1), 1);
        t1 = cyc;
        wait_starts(s0 + 3, 100, "s5_start3");
        check_eq("s5_retry_gap2", int'(cyc - t1 >= TIMEOUT && cyc - t1 <= TIMEOUT + 1), 1);
        check_eq("s5_retry_sel", start_sel, a);
        repeat (150) step();
        check_eq("s5_no_extra_retry", n_starts, s0 + 1 + RETRY);
        check_eq("s5_fault_error", int'(error), 1);
        check_eq("s5_fault_busy", int'(busy), 0);
        check_eq("s5_fault_display", int'(display_enable), 0);
        cur     = a;
        cp_mode = CP_NORMAL;
        cp_lat  = 20;
        a  = pick_new(cur, cur);
        s0 = n_starts;
        sw = SEL_W'(a);
        wait_starts(s0 + 1, 400, "s5_recover_start");
        check_eq("s5_error_cleared", int'(error), 0);
        wait_disp(1, 600, "s5_recover_show");
        check_eq("s5_recover_sel", int'(copier_seletor), a);
        cur = a;

        // Done still high from the previous pass: completion only after a low-then-high.
        cp_mode     = CP_STUCK;
        cp_lat      = 10;
        tick_period = 20;
        a  = pick_new(cur, cur);
        s0 = n_starts;
        sw = SEL_W'(a);
        wait_starts(s0 + 1, 200, "s6_start");
        t1 = last_start;
        wait_disp(1, 400, "s6_show");
        check_eq("s6_no_early_completion", int'(cyc - t1 > 30), 1);
        cur = a;

        // Reset in the middle of COPY.
        cp_mode     = CP_NORMAL;
        cp_lat      = 40;
        tick_period = 100;
        a  = pick_new(cur, cur);
        s0 = n_starts;
        sw = SEL_W'(a);
        wait_starts(s0 + 1, 400, "s7_start");
        repeat (10) step();
        #2 vga_reset = 1'b0;
        #1;
        check_eq("s7_rst_start", int'(copier_start), 0);
        check_eq("s7_rst_sel", int'(copier_seletor), 0);
        check_eq("s7_rst_display", int'(display_enable), 0);
        check_eq("s7_rst_busy", int'(busy), 0);
        check_eq("s7_rst_error", int'(error), 0);
        in_pass         = 0;
        pass_done       = 0;
        disp_prev       = 0;
        cp_hi           = 0;
        cp_lo           = 0;
        expect_start_at = -1;
        repeat (3) step();
        vga_reset = 1'b1;
        rel = cyc;
        wait_starts(s0 + 2, 400, "s7_fresh_start");
        check_eq("s7_debounced", int'(cyc - rel >= STABLE), 1);
        check_eq("s7_sel", start_sel, a);
        wait_disp(1, 600, "s7_show");
        check_eq("s7_seletor", int'(copier_seletor), a);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
